logic04_valve_sequencer: RTL and testbench



---
 rtl/logic04_pkg.sv | 44 ++++
 rtl/logic04_valve_sequencer_mux_encode.sv | 13 +
 rtl/logic04_valve_sequencer.sv | 177 +++++++++++++++++
 tb/tb_logic04_valve_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic04_pkg.sv
// logic04 valve sequencer shared types and valve tables.
// Masks mark lines opened (1 = open) for each trap corner.
package logic04_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETTLE_IN  = 3'd1,
        FILL       = 3'd2,
        FLUSH      = 3'd3,
        SETTLE_OUT = 3'd4
    } seq_state_t;

    localparam logic VALVE_CLOSED = 1'b1;
    localparam logic VALVE_OPEN   = 1'b0;

    localparam logic [5:0]  ALL_CLOSED_MUX   = 6'h3F;
    localparam logic [22:0] ALL_CLOSED_ARRAY = 23'h7FFFFF;

    // d0: c1,c5  d1: c1,c9  d2: c2,c14  d3: c2,c17
    localparam logic [22:0] FILL_MASK [4] = '{
        23'h000011,
        23'h000101,
        23'h002002,
        23'h010002
    };

    // d0: c7,c22  d1: c11,c22  d2: c15,c23  d3: c19,c23
    localparam logic [22:0] DRAIN_MASK [4] = '{
        23'h200040,
        23'h200400,
        23'h404000,
        23'h440000
    };

    // Turn an open-line mask into array drive levels.
    function automatic logic [22:0] array_lines(input logic [22:0] mask);
        logic [22:0] lines;
        for (int i = 0; i < 23; i++) begin
            lines[i] = mask[i] ? VALVE_OPEN : VALVE_CLOSED;
        end
        return lines;
    endfunction

endpackage

// File: rtl/logic04_valve_sequencer_mux_encode.sv
// logic04 mux encoder: 3-bit source to m1..m6 lines.
// Each source bit drives a complementary valve pair.
module logic04_mux_encode (
    input  logic [2:0] src,
    output logic [5:0] mux_lines
);

    // m1/m2 from s[0], m3/m4 from s[1], m5/m6 from s[2]
    always_comb begin
        mux_lines = {~src[2], src[2], ~src[1], src[1], ~src[0], src[0]};
    end

endmodule

// File: rtl/logic04_valve_sequencer.sv
// logic04 valve sequencer: settle, fill, flush, settle, done.
// Optional abort input/aborted flag under LOGIC04_SEQ_ABORT_EN.
module logic04_valve_sequencer
    import logic04_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int FLUSH_CYC  = 8,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_src,
    input  logic [1:0]         cmd_dst,
    input  logic [DWELL_W-1:0] cmd_dwell,
    output logic [5:0]         mux_ctrl,
    output logic [22:0]        array_ctrl,
    output logic               busy,
`ifdef LOGIC04_SEQ_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               done
);

    localparam int MAX_P = (SETTLE_CYC > FLUSH_CYC) ? SETTLE_CYC : FLUSH_CYC;
    localparam int P_W   = $clog2(MAX_P + 1);
    localparam int CNT_W = (DWELL_W > P_W) ? DWELL_W : P_W;

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         src_q;
    logic [1:0]         dst_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [5:0]         fill_mux;
    logic [5:0]         mux_d;
    logic [22:0]        arr_d;
    logic               done_d;
    logic               accept;
    logic               last;
    logic               abort_hit;

    assign accept = cmd_valid && cmd_ready;
    assign last   = (cnt_q == CNT_W'(1));

`ifdef LOGIC04_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q == SETTLE_IN || state_q == FILL);
`else
    assign abort_hit = 1'b0;
`endif

    logic04_mux_encode u_mux_encode (
        .src       (src_q),
        .mux_lines (fill_mux)
    );

    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch command fields on accept; dwell 0 runs as 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            dwell_q <= DWELL_W'(1);
        end else if (accept) begin
            src_q   <= cmd_src;
            dst_q   <= cmd_dst;
            dwell_q <= (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;
        end
    end

    // Next state: counter loaded on entry, leave when it hits 1
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE) ? cnt_q : cnt_q - CNT_W'(1);
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETTLE_IN;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                end
            end
            SETTLE_IN: begin
                if (abort_hit) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYC);
                end else if (last) begin
                    state_d = FILL;
                    cnt_d   = CNT_W'(dwell_q);
                end
            end
            FILL: begin
                if (abort_hit || last) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYC);
                end
            end
            FLUSH: begin
                if (last) begin
                    state_d = SETTLE_OUT;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                end
            end
            SETTLE_OUT: begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Valve levels for the upcoming cycle; first flush cycle stays shut
    always_comb begin
        mux_d = ALL_CLOSED_MUX;
        arr_d = ALL_CLOSED_ARRAY;
        unique case (1'b1)
            (state_d == FILL): begin
                mux_d = fill_mux;
                arr_d = array_lines(FILL_MASK[dst_q]);
            end
            (state_d == FLUSH && cnt_d != CNT_W'(FLUSH_CYC)): begin
                arr_d = array_lines(DRAIN_MASK[dst_q]);
            end
            default: begin
                mux_d = ALL_CLOSED_MUX;
                arr_d = ALL_CLOSED_ARRAY;
            end
        endcase
    end

    // Registered outputs; reset drops every valve shut at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_ctrl   <= ALL_CLOSED_MUX;
            array_ctrl <= ALL_CLOSED_ARRAY;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mux_ctrl   <= mux_d;
            array_ctrl <= arr_d;
            cmd_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

`ifdef LOGIC04_SEQ_ABORT_EN
    // Sticky abort flag, cleared by the next command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else if (accept) begin
            aborted <= 1'b0;
        end else if (abort_hit) begin
            aborted <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_logic04_valve_sequencer.sv
// Bench for logic04_valve_sequencer: vector table plus corner sequences.
// Define LOGIC04_SEQ_ABORT_EN to also exercise abort.
module tb_logic04_valve_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_src = '0;
    logic [1:0]  cmd_dst = '0;
    logic [15:0] cmd_dwell = '0;
    logic [5:0]  mux_ctrl;
    logic [22:0] array_ctrl;
    logic        busy;
    logic        done;
`ifdef LOGIC04_SEQ_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    int checks = 0;
    int errors = 0;

    logic04_valve_sequencer #(
        .SETTLE_CYC (4),
        .FLUSH_CYC  (8),
        .DWELL_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_dwell  (cmd_dwell),
        .mux_ctrl   (mux_ctrl),
        .array_ctrl (array_ctrl),
        .busy       (busy),
`ifdef LOGIC04_SEQ_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [1:0]  dst;
        logic [15:0] dwell;
        logic [5:0]  mux;
        logic [22:0] fill_arr;
        logic [22:0] drain_arr;
        int          total;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {mux_ctrl, array_ctrl, done, busy, cmd_ready};
    endfunction

    // Drive one command and check every cycle up to its done pulse
    task automatic run_vec(input int idx, input vec_t v);
        int d;
        logic [5:0]  em;
        logic [22:0] ea;
        logic        ed, eb, er;
        d = (v.dwell == 0) ? 1 : int'(v.dwell);
        @(negedge clk);
        cmd_src   = v.src;
        cmd_dst   = v.dst;
        cmd_dwell = v.dwell;
        cmd_valid = 1'b1;
        for (int n = 1; n <= v.total; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
            em = 6'h3F;
            ea = 23'h7FFFFF;
            ed = 1'b0;
            eb = 1'b1;
            er = 1'b0;
            if (n > 4 && n <= 4 + d) begin
                em = v.mux;
                ea = v.fill_arr;
            end else if (n > 4 + d + 1 && n <= 4 + d + 8) begin
                ea = v.drain_arr;
            end
            if (n == v.total) begin
                ed = 1'b1;
                eb = 1'b0;
                er = 1'b1;
            end
            check($sformatf("vec%0d_cyc%0d", idx, n), 64'(snap()),
                  64'({em, ea, ed, eb, er}));
        end
        @(negedge clk);
        check($sformatf("vec%0d_after_done", idx), 64'(snap()),
              64'({6'h3F, 23'h7FFFFF, 1'b0, 1'b0, 1'b1}));
    endtask

    initial begin
        int accepts;
        int dones;
        int first_done;
        int overlap;
        int rst_dones;
        logic done_ready;

        vecs[0] = '{3'd5, 2'd0, 16'd3, 6'b011001, 23'h7FFFEE, 23'h5FFFBF, 20};
        vecs[1] = '{3'd0, 2'd2, 16'd0, 6'h2A,     23'h7FDFFD, 23'h3FBFFF, 18};
        vecs[2] = '{3'd7, 2'd1, 16'd2, 6'h15,     23'h7FFEFE, 23'h5FFBFF, 19};
        vecs[3] = '{3'd2, 2'd3, 16'd1, 6'h26,     23'h7EFFFD, 23'h3BFFFF, 18};

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        check("reset_low", 64'(snap()),
              64'({6'h3F, 23'h7FFFFF, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_release", 64'(snap()),
              64'({6'h3F, 23'h7FFFFF, 1'b0, 1'b0, 1'b1}));
`ifdef LOGIC04_SEQ_ABORT_EN
        check("reset_aborted", 64'(aborted), 64'(1'b0));
`endif

        for (int i = 0; i < 4; i++) begin
            run_vec(i, vecs[i]);
        end

        // cmd_valid held across two commands
        @(negedge clk);
        cmd_src    = 3'd1;
        cmd_dst    = 2'd1;
        cmd_dwell  = 16'd0;
        cmd_valid  = 1'b1;
        accepts    = cmd_ready ? 1 : 0;
        dones      = 0;
        first_done = 0;
        overlap    = 0;
        done_ready = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (cmd_ready && busy) overlap++;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_done = c;
                    done_ready = cmd_ready;
                end
                if (dones == 2) begin
                    cmd_valid = 1'b0;
                    break;
                end
            end
            if (cmd_ready) accepts++;
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 64'(accepts), 64'(2));
        check("b2b_dones", 64'(dones), 64'(2));
        check("b2b_first_done", 64'(first_done), 64'(18));
        check("b2b_ready_in_done", 64'(done_ready), 64'(1'b1));
        check("b2b_ready_busy_overlap", 64'(overlap), 64'(0));
        @(negedge clk);
        check("b2b_no_third", 64'(busy), 64'(1'b0));

        // Reset pulse mid-fill, corner 3
        @(negedge clk);
        cmd_src   = 3'd2;
        cmd_dst   = 2'd3;
        cmd_dwell = 16'd10;
        cmd_valid = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("rst_mid_fill_open", 64'({mux_ctrl, array_ctrl}),
              64'({6'h26, 23'h7EFFFD}));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_closed", 64'(snap()),
              64'({6'h3F, 23'h7FFFFF, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        rst_dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) rst_dones++;
        end
        check("rst_mid_no_done", 64'(rst_dones), 64'(0));
        check("rst_mid_ready", 64'({cmd_ready, busy}), 64'(2'b10));

`ifdef LOGIC04_SEQ_ABORT_EN
        // Abort in FILL with a long dwell
        @(negedge clk);
        cmd_src   = 3'd3;
        cmd_dst   = 2'd0;
        cmd_dwell = 16'd100;
        cmd_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("abort_in_fill", 64'(array_ctrl), 64'(23'h7FFFEE));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_flush_first", 64'({mux_ctrl, array_ctrl}),
              64'({6'h3F, 23'h7FFFFF}));
        check("abort_flag_set", 64'(aborted), 64'(1'b1));
        first_done = 0;
        for (int n = 7; n <= 30; n++) begin
            @(negedge clk);
            if (n == 7) check("abort_drain", 64'(array_ctrl), 64'(23'h5FFFBF));
            if (done && first_done == 0) first_done = n;
        end
        check("abort_done_cycle", 64'(first_done), 64'(18));
        check("abort_flag_sticky", 64'(aborted), 64'(1'b1));
        @(negedge clk);
        cmd_dwell = 16'd1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_cleared", 64'(aborted), 64'(1'b0));
        dones = 0;
        for (int n = 0; n < 40 && dones == 0; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_next_done", 64'(dones), 64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
